// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline register chain.
package pipe_pkg;

    localparam int PIPE_XLEN = 32;

    // Instruction word loaded into a bubbled stage (addi x0, x0, 0).
    localparam logic [PIPE_XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    // Sequential fetch increment.
    localparam logic [PIPE_XLEN-1:0] PC_STEP = 32'd4;

    // Contents of one inter-stage register.
    typedef struct packed {
        logic                 valid;
        logic [PIPE_XLEN-1:0] pc;
        logic [PIPE_XLEN-1:0] instr;
    } stage_t;

    // An empty slot: not valid, NOP instruction, zero PC.
    function automatic stage_t make_bubble(input logic [PIPE_XLEN-1:0] nop);
        stage_t b;
        b.valid = 1'b0;
        b.pc    = '0;
        b.instr = nop;
        return b;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// One inter-stage register with flush > stall > load priority.
// A stalled upstream stage hands down a bubble instead of a copy of its
// instruction, and every bubble carries the NOP word with a zero PC.
module pipe_reg
    import pipe_pkg::*;
#(
    parameter logic [PIPE_XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   stall,
    input  logic   flush,
    input  logic   up_stall,
    input  stage_t src,
    output stage_t stage
);

    stage_t bubble;

    assign bubble = make_bubble(NOP_INSTR);

    // Flush beats stall, stall beats load; an invalid load becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= bubble;
        end else if (flush) begin
            stage <= bubble;
        end else if (!stall) begin
            if (src.valid && !up_stall) begin
                stage <= src;
            end else begin
                stage <= bubble;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_regs.sv
// PC register plus the FD/DE/EM/MW register chain of the 5-stage core.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_regs
    import pipe_pkg::*;
#(
    parameter int              XLEN      = PIPE_XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            f_stall_i,
    input  logic            d_stall_i,
    input  logic            e_stall_i,
    input  logic            m_stall_i,
    input  logic            w_stall_i,
    input  logic            fd_flush_i,
    input  logic            de_flush_i,
    input  logic            em_flush_i,
    input  logic            mw_flush_i,
    input  logic [XLEN-1:0] imem_instr_i,
    output logic [XLEN-1:0] pc_o,
    output logic            fd_valid_o,
    output logic            de_valid_o,
    output logic            em_valid_o,
    output logic            mw_valid_o,
    output logic [XLEN-1:0] fd_pc_o,
    output logic [XLEN-1:0] de_pc_o,
    output logic [XLEN-1:0] em_pc_o,
    output logic [XLEN-1:0] mw_pc_o,
    output logic [XLEN-1:0] fd_instr_o,
    output logic [XLEN-1:0] de_instr_o,
    output logic [XLEN-1:0] em_instr_o,
    output logic [XLEN-1:0] mw_instr_o,
    output logic            retire_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]     cycle_cnt_o,
    output logic [31:0]     retire_cnt_o,
    output logic [31:0]     bubble_cnt_o
`endif
);

    stage_t fd_src;
    stage_t fd;
    stage_t de;
    stage_t em;
    stage_t mw;

    // The fetch slot is always a real instruction; FD drops it if F stalls.
    assign fd_src = '{valid: 1'b1, pc: pc_o, instr: imem_instr_i};

    // Fetch PC: hold on F stall, otherwise step and wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_o <= RESET_PC;
        end else if (!f_stall_i) begin
            pc_o <= pc_o + PC_STEP;
        end
    end

    pipe_reg #(.NOP_INSTR(NOP_INSTR)) u_fd (
        .clk(clk_i), .rst(rst_i), .stall(d_stall_i), .flush(fd_flush_i),
        .up_stall(f_stall_i), .src(fd_src), .stage(fd)
    );

    pipe_reg #(.NOP_INSTR(NOP_INSTR)) u_de (
        .clk(clk_i), .rst(rst_i), .stall(e_stall_i), .flush(de_flush_i),
        .up_stall(d_stall_i), .src(fd), .stage(de)
    );

    pipe_reg #(.NOP_INSTR(NOP_INSTR)) u_em (
        .clk(clk_i), .rst(rst_i), .stall(m_stall_i), .flush(em_flush_i),
        .up_stall(e_stall_i), .src(de), .stage(em)
    );

    pipe_reg #(.NOP_INSTR(NOP_INSTR)) u_mw (
        .clk(clk_i), .rst(rst_i), .stall(w_stall_i), .flush(mw_flush_i),
        .up_stall(m_stall_i), .src(em), .stage(mw)
    );

    assign fd_valid_o = fd.valid;
    assign de_valid_o = de.valid;
    assign em_valid_o = em.valid;
    assign mw_valid_o = mw.valid;
    assign fd_pc_o    = fd.pc;
    assign de_pc_o    = de.pc;
    assign em_pc_o    = em.pc;
    assign mw_pc_o    = mw.pc;
    assign fd_instr_o = fd.instr;
    assign de_instr_o = de.instr;
    assign em_instr_o = em.instr;
    assign mw_instr_o = mw.instr;

    // An instruction retires when it sits in MW and writeback is not held.
    assign retire_o = mw.valid & ~w_stall_i;

`ifdef PIPE_PERF_CNT_EN
    // Free-running wrapping event counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_cnt_o  <= '0;
            retire_cnt_o <= '0;
            bubble_cnt_o <= '0;
        end else begin
            cycle_cnt_o <= cycle_cnt_o + 32'd1;
            if (retire_o) begin
                retire_cnt_o <= retire_cnt_o + 32'd1;
            end
            if (!mw.valid) begin
                bubble_cnt_o <= bubble_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pipe_stage_regs.md
# pipe_stage_regs

Pipeline register chain that consumes the per-stage stall and flush controls from the hazard/bubbling control unit and applies them to the PC and the four inter-stage registers (FD, DE, EM, MW) of the 5-stage core. It holds, advances or bubbles each stage and tracks instruction validity. It emits a per-cycle retire strobe and, optionally, performance counters. It sits between instruction memory, the stage datapaths and the control unit.

## Interface
- XLEN, 32, PC and instruction width
- RESET_PC, 0, PC value after reset
- NOP_INSTR, 32'h0000_0013, instruction word placed in a bubbled stage
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- f_stall_i, d_stall_i, e_stall_i, m_stall_i, w_stall_i  in  1 each  hold PC / FD / DE / EM / MW
- fd_flush_i, de_flush_i, em_flush_i, mw_flush_i  in  1 each  bubble the named register
- imem_instr_i  in  XLEN  instruction fetched at pc_o (same cycle)
- pc_o  out  XLEN  current fetch PC
- fd_/de_/em_/mw_ valid_o  out  1 each  stage holds a real instruction
- fd_/de_/em_/mw_ pc_o  out  XLEN each  PC of the instruction in that register
- fd_/de_/em_/mw_ instr_o  out  XLEN each  instruction word in that register
- retire_o  out  1  mw_valid_o & ~w_stall_i (combinational)
- cycle_cnt_o, retire_cnt_o, bubble_cnt_o  out  32 each  present only with PIPE_PERF_CNT_EN

## Operation
- PC: f_stall_i=1 holds it; otherwise pc_o <= pc_o+4, wrapping modulo 2^XLEN.
- Each register R with upstream source U, own stall S and own flush F. Priority is flush > stall > load:
  - F=1: valid<=0, instr<=NOP_INSTR, pc<=0.
  - else S=1: hold all fields.
  - else load U. The loaded valid is U.valid & ~(upstream stall).
- Sources and stalls per register:
  - FD: source is {imem_instr_i, pc_o, valid=1}, upstream stall f_stall_i, own stall d_stall_i.
  - DE: source FD, upstream d_stall_i, own e_stall_i.
  - EM: source DE, upstream e_stall_i, own m_stall_i.
  - MW: source EM, upstream m_stall_i, own w_stall_i.
- Effect: a stalled stage sends a bubble downstream rather than duplicating its instruction. A stall with a simultaneous flush on the same register flushes.
- A bubble in a register always shows instr = NOP_INSTR.
- Reset (asynchronous, any time, including mid-stall): pc_o=RESET_PC; all valid_o=0, instr_o=NOP_INSTR, pc_o fields=0; counters=0.

## Timing
- Every register updates on the rising clk_i edge following the control values it sees.
- Fetch-to-MW latency with no stalls: 4 cycles. The instruction at pc_o in cycle n appears in MW in cycle n+4, and retire_o is high that cycle.
- Reset values hold until the first rising edge after rst_i deasserts.
- The control unit's bubbling pattern (f_stall_i=fd_flush_i=1 for 4 of every 5 cycles) gives exactly one valid instruction per 5 cycles through every stage.

## Configuration
- PIPE_PERF_CNT_EN defined: three 32-bit wrapping counters are built.
  - cycle_cnt_o increments every cycle.
  - retire_cnt_o increments when retire_o=1.
  - bubble_cnt_o increments when mw_valid_o=0.
- PIPE_PERF_CNT_EN undefined: the counter ports and logic are absent.

## Structure
- Package pipe_pkg holds:
  - stage_t, a packed struct {valid, pc[XLEN-1:0], instr[XLEN-1:0]}
  - NOP_INSTR default constant
  - PC_STEP=4
- Sub-module pipe_reg: one stage register with stall/flush/upstream-stall inputs and stage_t in/out. It is instantiated four times. The PC register and counters live at top level.

## Test plan
- Reset, then no stalls with imem_instr_i=PC-derived words: cycle 4 shows mw_pc_o=0, mw_valid_o=1, retire_o=1. One retire per cycle after that, with mw_pc_o advancing by 4.
- Repeating pattern f_stall_i=fd_flush_i=1 for 4 cycles out of 5:
  - PC advances once per 5 cycles.
  - Exactly one valid MW entry per 5 cycles.
  - bubble_cnt_o=4 and retire_cnt_o=1 per period.
- d_stall_i=1 for 2 cycles with FD holding PC 0x8:
  - FD holds 0x8 and pc_o does not change only if f_stall_i is also 1.
  - DE receives 2 bubbles.
  - 0x8 retires exactly once.
- d_stall_i=1 and de_flush_i=1 in the same cycle: DE becomes a bubble (instr=32'h13, valid=0). FD still holds.
- Assert rst_i asynchronously mid-stream between clock edges: all valids drop and pc_o=RESET_PC immediately. Counters read 0.
- PC preloaded near wrap (RESET_PC=32'hFFFF_FFFC): the next PC is 0.
